// File: rtl/flopr_pipe_pkg.sv
// Shared definitions for the flopr_pipe elastic pipeline register.
// Holds the default geometry and the count-width helper used by the
// interface, the top level and any block that needs to size a count port.
package flopr_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 3;

    // Width of the occupancy counter: wide enough for 0..depth+1 so the
    // same port width serves both the plain and the skid-buffered build.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/flopr_pipe_if.sv
// Valid/ready stream bundle for flopr_pipe: upstream side (in_valid/in_ready/d),
// downstream side (out_valid/out_ready/q) and the occupancy count.
// 'master' is the environment driving the pipe, 'slave' is the pipe itself.
interface flopr_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    localparam int CW = flopr_pipe_pkg::cnt_w(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, d, out_ready,
        input  in_ready, out_valid, q, count
    );

    modport slave (
        input  in_valid, d, out_ready,
        output in_ready, out_valid, q, count
    );

endinterface

// File: rtl/flopr_pipe_stage.sv
// One pipeline slot: a valid bit plus a WIDTH-bit data register.
// clear_i empties the slot (data kept), load_i takes valid_i and, only when
// valid_i is set, data_i -- so a loaded bubble leaves the old data in place.
module flopr_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Next-state: clear beats load, load beats hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    // Slot registers; asynchronous reset empties the slot at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/flopr_pipe.sv
// flopr_pipe: DEPTH-stage elastic pipeline register with valid/ready on both
// sides, full throughput when unstalled, bubble collapsing and a sync flush.
// Optional macro FLOPR_PIPE_SKID_EN inserts a one-entry skid slot ahead of
// stage 0 so that in_ready comes straight from a register (capacity DEPTH+1).
module flopr_pipe
    import flopr_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    flopr_pipe_if.slave   pipe
);

    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("flopr_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] stg_valid;
    logic [WIDTH-1:0] stg_data [DEPTH];
    logic [DEPTH-1:0] rdy;

    logic             in_ready_int;
    logic             in_xfer;
    logic             out_xfer;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    assign in_xfer  = pipe.in_valid & in_ready_int;
    assign out_xfer = stg_valid[DEPTH-1] & pipe.out_ready;

`ifdef FLOPR_PIPE_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // The skid slot only captures when stage 0 cannot take the beat, and
    // releases into stage 0 as soon as stage 0 frees up.
    flopr_pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .load_i  (~skid_valid | rdy[0]),
        .valid_i (in_xfer & ~rdy[0]),
        .data_i  (pipe.d),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    // in_ready depends only on the skid register, never on out_ready.
    assign in_ready_int = ~skid_valid & ~clear & ~reset;
    // A parked skid beat is older than anything on d, so it goes first.
    assign src_valid    = skid_valid | in_xfer;
    assign src_data     = skid_valid ? skid_data : pipe.d;
`else
    assign in_ready_int = rdy[0] & ~clear & ~reset;
    assign src_valid    = in_xfer;
    assign src_data     = pipe.d;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             stg_valid_in;
            logic [WIDTH-1:0] stg_data_in;

            if (gi == 0) begin : g_head
                assign stg_valid_in = src_valid;
                assign stg_data_in  = src_data;
            end else begin : g_body
                assign stg_valid_in = stg_valid[gi-1];
                assign stg_data_in  = stg_data[gi-1];
            end

            // A stage may load when downstream is draining or any stage from
            // here to the output is empty; written flat so the backward
            // ready chain does not feed on itself.
            assign rdy[gi] = pipe.out_ready | ~(&stg_valid[DEPTH-1:gi]);

            flopr_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .clear_i (clear),
                .load_i  (rdy[gi]),
                .valid_i (stg_valid_in),
                .data_i  (stg_data_in),
                .valid_o (stg_valid[gi]),
                .data_o  (stg_data[gi])
            );
        end
    endgenerate

    logic [CW-1:0] count_q, count_d;

    // Occupancy: +1 per accepted beat, -1 per delivered beat, flush to zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    // Occupancy register, emptied immediately by reset like the stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pipe.in_ready  = in_ready_int;
    assign pipe.out_valid = stg_valid[DEPTH-1];
    assign pipe.q         = stg_data[DEPTH-1];
    assign pipe.count     = count_q;

endmodule

// File: tb/tb_flopr_pipe.sv
// Self-checking bench for flopr_pipe: directed scenarios with literal
// expectations plus a randomized phase, all tracked by a queue-based model
// (FIFO order, occupancy, earliest-delivery time of each beat).
module tb_flopr_pipe;

    localparam int               W  = 8;
    localparam int               D  = 3;
    localparam logic [W-1:0]     RV = 8'h00;
`ifdef FLOPR_PIPE_SKID_EN
    localparam int CAP  = D + 1;
    localparam bit SKID = 1'b1;
`else
    localparam int CAP  = D;
    localparam bit SKID = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;

    flopr_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

    flopr_pipe #(
        .WIDTH     (W),
        .DEPTH     (D),
        .RESET_VAL (RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .pipe  (bus)
    );

    initial begin
        #2;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [W-1:0] data;
        int           acc;
    } beat_t;

    beat_t sb[$];
    int    last_exit = -1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a beat accepted in cycle a can be at the output no earlier than
    // a+D, and no earlier than one cycle after the previous beat left.
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_q;

    always @(negedge clk) begin
        bit exp_ov;
        bit exp_ir;
        bit in_x;
        bit out_x;
        int ready_at;
        cyc++;
        if (reset) begin
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_count",     32'(bus.count),     32'd0);
            chk("rst_q",         32'(bus.q),         32'(RV));
            chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            chk("count", 32'(bus.count), 32'(sb.size()));
            if (SKID) exp_ir = !clear && (sb.size() < CAP);
            else      exp_ir = !clear && ((sb.size() < CAP) || bus.out_ready);
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
            exp_ov = 1'b0;
            if (sb.size() > 0) begin
                ready_at = sb[0].acc + D;
                if (last_exit + 1 > ready_at) ready_at = last_exit + 1;
                exp_ov = (cyc >= ready_at);
            end
            chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            if (exp_ov) chk("q_order", 32'(bus.q), 32'(sb[0].data));
            if (prev_hold) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_q",     32'(bus.q),         32'(prev_q));
            end
            prev_hold = bus.out_valid && !bus.out_ready && !clear;
            prev_q    = bus.q;
            out_x = exp_ov && bus.out_ready;
            in_x  = bus.in_valid && exp_ir;
            if (out_x) begin
                void'(sb.pop_front());
                last_exit = cyc;
            end
            if (clear) sb.delete();
            else if (in_x) sb.push_back('{data: bus.d, acc: cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] vals [4];
        logic [W-1:0] pat;
        int           k;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

        // Reset held with a beat offered on the input
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.d         = 8'hAA;
        bus.out_ready = 1'b0;
        #8;
        chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_q",         32'(bus.q),         32'h00);
        chk("t1_count",     32'(bus.count),     32'd0);
        #10;
        chk("t1_out_valid_late", 32'(bus.out_valid), 32'd0);
        chk("t1_count_late",     32'(bus.count),     32'd0);
        #2;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        step();

        // Back-to-back streaming
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4 + D + 1; i++) begin
            if (i < 4) begin
                bus.in_valid = 1'b1;
                bus.d        = vals[i];
            end else begin
                bus.in_valid = 1'b0;
            end
            #2;
            if (i < 4) chk("t2_in_ready", 32'(bus.in_ready), 32'd1);
            if (i >= D && i < D + 4) begin
                chk("t2_q",         32'(bus.q),         32'(vals[i-D]));
                chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
            end
            step();
        end

        // Backpressure until full, then drain
        bus.out_ready = 1'b0;
        for (k = 0; k < 20; k++) begin
            bus.in_valid = 1'b1;
            bus.d        = W'($urandom);
            #2;
            if (!bus.in_ready) break;
            step();
        end
        chk("t3_hit_full",   32'(k < 20),       32'd1);
        chk("t3_full_count", 32'(bus.count),    32'(CAP));
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i <= CAP; i++) begin
            #2;
            chk("t3_drain_count", 32'(bus.count), 32'(CAP - i));
            step();
        end

        // Full stages, simultaneous push and pop
        bus.out_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            bus.in_valid = 1'b1;
            bus.d        = W'($urandom_range(0, 63));
            step();
        end
        pat           = 8'h5A;
        bus.out_ready = 1'b1;
        for (int i = 0; i <= D; i++) begin
            bus.in_valid = 1'b1;
            bus.d        = (i == 0) ? pat : W'(8'h80 + i);
            #2;
            chk("t4_count", 32'(bus.count), 32'(D));
            if (i == D) begin
                chk("t4_q",         32'(bus.q),         32'(pat));
                chk("t4_out_valid", 32'(bus.out_valid), 32'd1);
            end
            step();
        end

        // Flush with two beats in flight
        bus.in_valid = 1'b0;
        repeat (CAP + 2) step();
        #2;
        chk("t5_empty_before", 32'(bus.count), 32'd0);
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.d        = W'($urandom_range(0, 127));
            step();
        end
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.d        = 8'hFF;
        #2;
        chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        #2;
        chk("t5_count",     32'(bus.count),     32'd0);
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < D + 3; i++) begin
            #2;
            chk("t5_no_output", 32'(bus.out_valid), 32'd0);
            step();
        end

        // Asynchronous reset while full
        bus.out_ready = 1'b0;
        for (int i = 0; i < CAP + 1; i++) begin
            bus.in_valid = 1'b1;
            bus.d        = W'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        #2;
        chk("t6_full_count", 32'(bus.count), 32'(CAP));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_count",     32'(bus.count),     32'd0);
        chk("t6_q",         32'(bus.q),         32'(RV));
        chk("t6_in_ready",  32'(bus.in_ready),  32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        step();
        pat           = 8'hC3;
        bus.out_ready = 1'b1;
        for (int i = 0; i <= D; i++) begin
            bus.in_valid = (i == 0);
            bus.d        = pat;
            #2;
            if (i == D) begin
                chk("t6_resume_q",     32'(bus.q),         32'(pat));
                chk("t6_resume_valid", 32'(bus.out_valid), 32'd1);
            end
            step();
        end

        // Randomized traffic with occasional long stalls and flushes
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.d         = W'($urandom);
            bus.out_ready = ((i % 50) > 41) ? 1'b0 : ($urandom_range(0, 3) != 0);
            clear         = ($urandom_range(0, 49) == 0);
            step();
        end
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (CAP + 4) step();
        #2;
        chk("final_empty", 32'(bus.count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
